// File: rtl/int_iq_slot_reclaim.sv
// Integer issue-queue slot reclaim: tracks slot occupancy, collects slots vacated by
// issue and returns them lowest-index-first, one per cycle, to the slot free list.

module int_iq_slot_cell (
  input  logic Clk,
  input  logic Rest,
  input  logic Flush,
  input  logic rel_hit,
  input  logic iss_hit,
  input  logic alloc_hit,
  output logic occ,
  output logic pend
);
  // An issue that lands on the slot being released keeps it pending: it is a new vacancy.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      occ  <= 1'b0;
      pend <= 1'b0;
    end else if (Flush) begin
      occ  <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (iss_hit) begin
        occ  <= 1'b0;
        pend <= 1'b1;
      end else if (rel_hit) begin
        pend <= 1'b0;
      end
      if (alloc_hit) occ <= 1'b1;
    end
  end
endmodule

module int_iq_slot_reclaim #(
  parameter int SLOTW   = 5,
  parameter int SLOTNUM = 32
) (
  input  logic               Clk,
  input  logic               Rest,
  input  logic               AllocValid,
  input  logic [SLOTW-1:0]   AllocSlot,
  input  logic [1:0]         IssueValid,
  input  logic [SLOTW-1:0]   IssueSlot0,
  input  logic [SLOTW-1:0]   IssueSlot1,
  input  logic               Flush,
  input  logic               FreeListFull,
  output logic               RelWable,
  output logic [SLOTW-1:0]   RelDin,
  output logic [SLOTNUM-1:0] Occupied,
  output logic [SLOTW:0]     PendingCnt,
  output logic               Idle,
  output logic               ErrBadRelease,
  output logic               ErrDoubleAlloc
);

  logic [SLOTNUM-1:0] pending;
  logic [SLOTNUM-1:0] iss_vec, rel_vec, alloc_vec;
  logic [SLOTNUM-1:0] occ_mid, pend_mid, pend_next;
  logic               iss0_ok, iss1_dup, iss1_ok;
  logic               bad_rel, dbl_alloc;
  logic [SLOTW:0]     cnt_next;

  // Lowest pending index wins the single write port.
  always_comb begin
    RelDin = '0;
    for (int i = SLOTNUM - 1; i >= 0; i--)
      if (pending[i]) RelDin = SLOTW'(i);
  end

  assign RelWable = (|pending) & ~FreeListFull & ~Flush;

  assign iss0_ok  = IssueValid[0] & Occupied[IssueSlot0];
  assign iss1_dup = IssueValid[1] & IssueValid[0] & (IssueSlot1 == IssueSlot0);
  assign iss1_ok  = IssueValid[1] & ~iss1_dup & Occupied[IssueSlot1];
  assign bad_rel  = ~Flush & ((IssueValid[0] & ~Occupied[IssueSlot0]) |
                              (IssueValid[1] & (iss1_dup | ~Occupied[IssueSlot1])));

  genvar g;
  generate
    for (g = 0; g < SLOTNUM; g++) begin : g_slot
      localparam logic [SLOTW-1:0] IDX = SLOTW'(g);
      assign iss_vec[g]   = (iss0_ok & (IssueSlot0 == IDX)) | (iss1_ok & (IssueSlot1 == IDX));
      assign rel_vec[g]   = RelWable & (RelDin == IDX);
      assign alloc_vec[g] = AllocValid & (AllocSlot == IDX);

      int_iq_slot_cell u_cell (
        .Clk       (Clk),
        .Rest      (Rest),
        .Flush     (Flush),
        .rel_hit   (rel_vec[g]),
        .iss_hit   (iss_vec[g]),
        .alloc_hit (alloc_vec[g]),
        .occ       (Occupied[g]),
        .pend      (pending[g])
      );
    end
  endgenerate

  // Alloc is judged against the state after this edge's release and issue are applied.
  assign occ_mid   = Occupied & ~iss_vec;
  assign pend_mid  = (pending & ~rel_vec) | iss_vec;
  assign pend_next = Flush ? '0 : pend_mid;
  assign dbl_alloc = ~Flush & AllocValid & (occ_mid[AllocSlot] | pend_mid[AllocSlot]);

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < SLOTNUM; i++)
      cnt_next = cnt_next + {{SLOTW{1'b0}}, pend_next[i]};
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      PendingCnt     <= '0;
      Idle           <= 1'b1;
      ErrBadRelease  <= 1'b0;
      ErrDoubleAlloc <= 1'b0;
    end else begin
      PendingCnt <= cnt_next;
      Idle       <= ~(|pend_next);
      if (bad_rel)   ErrBadRelease  <= 1'b1;
      if (dbl_alloc) ErrDoubleAlloc <= 1'b1;
    end
  end

endmodule

// File: tb/tb_int_iq_slot_reclaim.sv
// Directed bench for int_iq_slot_reclaim: a vector table for the main flows plus
// hand-written sequences for flush, async reset and same-edge corner cases.

module tb_int_iq_slot_reclaim;
  localparam int SLOTW   = 5;
  localparam int SLOTNUM = 32;

  logic               Clk = 1'b0;
  logic               Rest;
  logic               AllocValid;
  logic [SLOTW-1:0]   AllocSlot;
  logic [1:0]         IssueValid;
  logic [SLOTW-1:0]   IssueSlot0, IssueSlot1;
  logic               Flush, FreeListFull;
  logic               RelWable;
  logic [SLOTW-1:0]   RelDin;
  logic [SLOTNUM-1:0] Occupied;
  logic [SLOTW:0]     PendingCnt;
  logic               Idle, ErrBadRelease, ErrDoubleAlloc;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  int_iq_slot_reclaim #(.SLOTW(SLOTW), .SLOTNUM(SLOTNUM)) dut (
    .Clk(Clk), .Rest(Rest), .AllocValid(AllocValid), .AllocSlot(AllocSlot),
    .IssueValid(IssueValid), .IssueSlot0(IssueSlot0), .IssueSlot1(IssueSlot1),
    .Flush(Flush), .FreeListFull(FreeListFull), .RelWable(RelWable), .RelDin(RelDin),
    .Occupied(Occupied), .PendingCnt(PendingCnt), .Idle(Idle),
    .ErrBadRelease(ErrBadRelease), .ErrDoubleAlloc(ErrDoubleAlloc)
  );

  typedef struct {
    logic       av;
    logic [4:0] as;
    logic [1:0] iv;
    logic [4:0] s0, s1;
    logic       fl, full;
    logic       wable;
    logic [4:0] din;
    logic [5:0] cnt;
    logic       idle, ebad, edbl;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] as, input logic [1:0] iv,
                       input logic [4:0] s0, input logic [4:0] s1,
                       input logic fl, input logic full);
    AllocValid = av; AllocSlot = as; IssueValid = iv;
    IssueSlot0 = s0; IssueSlot1 = s1; Flush = fl; FreeListFull = full;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    Rest = 1'b1;
    tick(); tick();
    Rest = 1'b0;
  endtask

  task automatic add(input logic av, input logic [4:0] as, input logic [1:0] iv,
                     input logic [4:0] s0, input logic [4:0] s1, input logic full,
                     input logic wable, input logic [4:0] din, input logic [5:0] cnt,
                     input logic idle, input logic ebad, input logic edbl);
    vec_t v;
    v.av = av; v.as = as; v.iv = iv; v.s0 = s0; v.s1 = s1; v.fl = 1'b0; v.full = full;
    v.wable = wable; v.din = din; v.cnt = cnt; v.idle = idle; v.ebad = ebad; v.edbl = edbl;
    vecs.push_back(v);
  endtask

  initial begin
    // Each row: inputs for the cycle; expected outputs seen mid-cycle.
    // alloc 7, issue 7, release 7
    add(1, 7, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 7, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 7, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    // slots 11 and 3 issued together, returned lowest first
    add(1, 11, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
    add(1, 3, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 0, 3, 11, 3, 0,  0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 3, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 11, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    // slot 19 held back by a full free list for three cycles
    add(1, 19, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 19, 0, 1,  0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 19, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 19, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 19, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 19, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    // bad release of 5, then double alloc of 31; both sticky
    add(0, 0, 1, 5, 0, 0,   0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 0);
    add(1, 31, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
    add(1, 31, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 1);

    Rest = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    chk("rst_wable", 32'(RelWable), 0);
    chk("rst_din",   32'(RelDin), 0);
    chk("rst_occ",   Occupied, 0);
    chk("rst_cnt",   32'(PendingCnt), 0);
    chk("rst_idle",  32'(Idle), 1);
    chk("rst_errs",  {30'd0, ErrBadRelease, ErrDoubleAlloc}, 0);
    tick();
    Rest = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].av, vecs[i].as, vecs[i].iv, vecs[i].s0, vecs[i].s1, vecs[i].fl, vecs[i].full);
      @(negedge Clk);
      chk($sformatf("v%0d_wable", i), 32'(RelWable), 32'(vecs[i].wable));
      chk($sformatf("v%0d_din", i),   32'(RelDin), 32'(vecs[i].din));
      chk($sformatf("v%0d_cnt", i),   32'(PendingCnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_idle", i),  32'(Idle), 32'(vecs[i].idle));
      chk($sformatf("v%0d_ebad", i),  32'(ErrBadRelease), 32'(vecs[i].ebad));
      chk($sformatf("v%0d_edbl", i),  32'(ErrDoubleAlloc), 32'(vecs[i].edbl));
      tick();
    end

    // Flush with pending {23,27}, occupied {31}, alloc 15 in the flush cycle
    do_reset();
    drive(1, 23, 0, 0, 0, 0, 0); tick();
    drive(1, 27, 0, 0, 0, 0, 0); tick();
    drive(1, 31, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 3, 23, 27, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge Clk);
    chk("fl_pre_cnt", 32'(PendingCnt), 2);
    chk("fl_pre_occ", Occupied, 32'h8000_0000);
    tick();
    drive(1, 15, 0, 0, 0, 1, 0);
    @(negedge Clk);
    chk("fl_wable", 32'(RelWable), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    chk("fl_occ",   Occupied, 0);
    chk("fl_cnt",   32'(PendingCnt), 0);
    chk("fl_idle",  32'(Idle), 1);
    chk("fl_wable2", 32'(RelWable), 0);
    tick();

    // Async reset mid-cycle while slot 7 is being released, with an error flag set
    do_reset();
    drive(0, 0, 1, 2, 0, 0, 0); tick();
    drive(1, 7, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 7, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    chk("ar_pre_wable", 32'(RelWable), 1);
    chk("ar_pre_din",   32'(RelDin), 7);
    chk("ar_pre_ebad",  32'(ErrBadRelease), 1);
    Rest = 1'b1;
    #1;
    chk("ar_wable", 32'(RelWable), 0);
    chk("ar_occ",   Occupied, 0);
    chk("ar_cnt",   32'(PendingCnt), 0);
    chk("ar_idle",  32'(Idle), 1);
    chk("ar_errs",  {30'd0, ErrBadRelease, ErrDoubleAlloc}, 0);
    tick();
    Rest = 1'b0;

    // Both ports issue slot 9: port 0 honoured, error flagged
    do_reset();
    drive(1, 9, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 3, 9, 9, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    chk("dp_ebad",  32'(ErrBadRelease), 1);
    chk("dp_cnt",   32'(PendingCnt), 1);
    chk("dp_din",   32'(RelDin), 9);
    chk("dp_occ",   Occupied, 0);
    tick();
    @(negedge Clk);
    chk("dp_idle",  32'(Idle), 1);
    tick();

    // Re-issue of a slot while it is being released, without re-allocation
    do_reset();
    drive(1, 6, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 6, 0, 0, 0); tick();
    drive(0, 0, 1, 6, 0, 0, 0);
    @(negedge Clk);
    chk("ri_wable", 32'(RelWable), 1);
    chk("ri_ebad0", 32'(ErrBadRelease), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    chk("ri_ebad",  32'(ErrBadRelease), 1);
    chk("ri_cnt",   32'(PendingCnt), 0);
    tick();

    // Same-edge issue and alloc of slot 4: issue first, then alloc flagged
    do_reset();
    drive(1, 4, 0, 0, 0, 0, 0); tick();
    drive(1, 4, 2, 0, 4, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    chk("sa_edbl",  32'(ErrDoubleAlloc), 1);
    chk("sa_ebad",  32'(ErrBadRelease), 0);
    chk("sa_occ",   Occupied, 32'h0000_0010);
    chk("sa_cnt",   32'(PendingCnt), 1);
    chk("sa_din",   32'(RelDin), 4);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
